// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// =============================================================================
// Module      : alu_cmd_issuer
// Description : Issues one command at a time to an ALU datapath, waits LAT
//               cycles, captures the result and holds it until consumed.
// Revision    : 1.0  initial release
// =============================================================================
module alu_cmd_issuer #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_s,
    input  logic [1:0]  cmd_s1,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_s,
    output logic [1:0]  alu_s1,
    input  logic [15:0] alu_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy,
    output logic [7:0]  op_count
);

    localparam logic [3:0] c_LAT = 4'(LAT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic        r_alu_s;
    logic [1:0]  r_alu_s1;
    logic [15:0] r_rsp_data;
    logic [7:0]  r_op_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_alu_a    <= 8'd0;
            r_alu_b    <= 8'd0;
            r_alu_s    <= 1'b0;
            r_alu_s1   <= 2'd0;
            r_rsp_data <= 16'd0;
            r_op_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_alu_a  <= cmd_a;
                        r_alu_b  <= cmd_b;
                        r_alu_s  <= cmd_s;
                        r_alu_s1 <= cmd_s1;
                        r_cnt    <= c_LAT;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Counter reads 1 on the edge LAT cycles after acceptance.
                    if (r_cnt == 4'd1) begin
                        r_rsp_data <= alu_out;
                        r_cnt      <= 4'd0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_op_count <= r_op_count + 8'd1;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status flags are masked by reset so they read low for the whole time
    // reset is held, including the cycle before the first reset edge.
    assign cmd_ready = (r_state == S_IDLE) && reset;
    assign rsp_valid = (r_state == S_DONE) && reset;
    assign busy      = (r_state != S_IDLE) && reset;

    assign alu_a    = r_alu_a;
    assign alu_b    = r_alu_b;
    assign alu_s    = r_alu_s;
    assign alu_s1   = r_alu_s1;
    assign rsp_data = r_rsp_data;
    assign op_count = r_op_count;

endmodule
`default_nettype wire
